decode_ctrl_stage: RTL and testbench
====================================

# decode_ctrl_stage

Registered, parametrised decode/control stage for the pipelined RV32I core. It takes a fetched instruction over a valid/ready handshake and decodes it into the control bundle. The bundle is held in an ID/EX control register with stall, flush and load-use bubble insertion. With the M extension compiled in, a small FSM also blocks issue while a multi-cycle divide is outstanding. It sits between the IF/ID register and the execute stage.

## Interface
- DIV_LATENCY, 4, cycles the divider occupies; legal 1..64
- REG_ADDR_W, 5, register-index width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instr is valid
- in_ready  out  1  stage accepts instr this cycle
- instr  in  32  instruction word
- flush  in  1  kill ID/EX contents and the incoming instruction
- ex_ready  in  1  execute stage accepts the held bundle
- out_valid  out  1  bundle is valid
- out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg, out_branch, out_jump, out_alu_src, out_illegal  out  1 each  control flags
- out_alu_op  out  2  00 add, 01 branch-compare, 10 funct-decoded, 11 mul/div
- out_a_sel  out  2  ALU A source: 0 rs1, 1 PC, 2 zero
- out_imm_sel  out  3  I=0, S=1, B=2, U=3, J=4
- out_funct3  out  3  instr[14:12]
- out_funct7_5  out  1  instr[30]
- out_rd, out_rs1, out_rs2  out  REG_ADDR_W each  register indices
- muldiv_busy  out  1  divide FSM not in IDLE

## Operation
- Decode (combinational):
  - LOAD: rw, mr, m2r, src, I.
  - STORE: mw, src, S.
  - BRANCH: br, op=01, src=0, B.
  - OP-IMM: rw, op=10, src, I.
  - OP: rw, op=10.
  - JAL: rw, jump, a_sel=1, src, J.
  - JALR: rw, jump, src, I.
  - LUI: rw, a_sel=2, src, U.
  - AUIPC: rw, a_sel=1, src, U.
  - Any other opcode: illegal=1 and all enables 0.
- rd is forced to 0 for STORE/BRANCH. rs1 and rs2 are extracted raw.
- advance = !out_valid || ex_ready.
- hazard = out_valid && out_mem_read && out_rd!=0 && (dec_rs1==out_rd || (uses_rs2 && dec_rs2==out_rd)).
  - uses_rs2 = OP, STORE or BRANCH.
- in_ready = advance && !flush && !hazard && !div_wait.
- Register update, in priority order:
  - flush: out_valid ← 0.
  - Otherwise, if advance: load the decoded bundle with out_valid ← in_valid && in_ready.
  - Otherwise: hold.
- A bubble is out_valid=0. Bundle fields are don't-care when out_valid=0.
- Divide FSM, states IDLE and DIV_WAIT:
  - An accepted DIV/DIVU/REM/REMU (OP, funct7=0000001, funct3[2]=1) with DIV_LATENCY>1 loads cnt ← DIV_LATENCY-1 and goes to DIV_WAIT.
  - In DIV_WAIT, cnt decrements every cycle, independent of ex_ready. The FSM returns to IDLE on the cycle cnt reaches 1→0.
  - flush forces IDLE and cnt ← 0.
- MUL-family ops are single-cycle: op=11, no FSM entry.
- An illegal instruction still issues with out_valid=1 and out_illegal=1 so execute can trap.

## Timing
- Reset state: every output 0, FSM IDLE, cnt 0. in_ready is therefore 1 after reset, assuming flush=0.
- Latency: an instruction accepted at edge N appears on out_* after edge N.
- Throughput is 1 per cycle when hazard-free and ex_ready=1.
- Load-use hazard: exactly one bubble, then the dependent instruction is accepted the following cycle.
- Divide: in_ready stays low for DIV_LATENCY-1 cycles after the issuing edge.
- Outputs are stable while out_valid && !ex_ready.
- flush together with in_valid: the instruction is not accepted (in_ready=0).
- flush together with a stall: flush wins.
- Reset asserted mid-divide: immediate return to IDLE.
- cnt width is $clog2(DIV_LATENCY+1).

## Configuration
- RV_M_EXT_EN defined:
  - OP with funct7=0000001 decodes as mul/div (op=11).
  - Divide FSM and muldiv_busy are present.
- RV_M_EXT_EN undefined:
  - Such encodings decode illegal.
  - FSM logic is removed; muldiv_busy is tied 0.

## Structure
- Shared package rv_ctrl_pkg holds:
  - imm_sel_e enum
  - opcode localparams
  - alu_op and a_sel encodings
  - packed struct ctrl_bundle_t
- One sub-module, ctrl_decode: purely combinational instr → ctrl_bundle_t plus uses_rs2/is_div flags.
- Top holds the register, hazard logic and FSM.

## Test plan
- Reset, then lw x5,0(x1) = 0x0000A283 → next cycle: out_valid=1, mem_read=1, reg_write=1, mem_to_reg=1, alu_src=1, imm_sel=0, rd=5.
- 0x0000A283 then add x6,x5,x2 = 0x00228333 back-to-back → in_ready=0 for one cycle, one bubble, then add issues with alu_op=10, rd=6.
- DIV_LATENCY=4, div x3,x4,x5 = 0x025241B3 → out_alu_op=11, muldiv_busy=1 and in_ready=0 for exactly 3 cycles.
- With 0x025241B3 out_valid, hold ex_ready=0 for 3 cycles → out_* unchanged and in_ready=0. Raise ex_ready=1 → next instruction accepted.
- flush=1 while in_valid=1 and DIV_WAIT active → next cycle: out_valid=0, muldiv_busy=0, in_ready=1.
- 0x0000007F → out_illegal=1 with all enables 0. Without RV_M_EXT_EN, 0x025241B3 → out_illegal=1.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared decode/control definitions for the RV32I decode stage:
// opcodes, ALU/A-source encodings, immediate selector and the control bundle.
package rv_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;
  localparam logic [1:0] ALU_OP_MULDIV = 2'b11;

  localparam logic [1:0] A_SEL_RS1  = 2'd0;
  localparam logic [1:0] A_SEL_PC   = 2'd1;
  localparam logic [1:0] A_SEL_ZERO = 2'd2;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic       illegal;
    logic [1:0] alu_op;
    logic [1:0] a_sel;
    imm_sel_e   imm_sel;
    logic [2:0] funct3;
    logic       funct7_5;
  } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational RV32I instruction decoder producing the control bundle,
// register indices and the hazard/divide helper flags. M-extension under RV_M_EXT_EN.
module ctrl_decode
  import rv_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [31:0]           instr,
  output ctrl_bundle_t          ctrl,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [REG_ADDR_W-1:0] rs1,
  output logic [REG_ADDR_W-1:0] rs2,
  output logic                  uses_rs2,
  output logic                  is_div
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic       no_rd;

  assign opcode = instr[6:0];
  assign funct7 = instr[31:25];

  always_comb begin
    ctrl          = '0;
    ctrl.imm_sel  = IMM_I;
    ctrl.alu_op   = ALU_OP_ADD;
    ctrl.a_sel    = A_SEL_RS1;
    ctrl.funct3   = instr[14:12];
    ctrl.funct7_5 = instr[30];
    uses_rs2      = 1'b0;
    is_div        = 1'b0;
    no_rd         = 1'b0;

    case (opcode)
      OPC_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
      end
      OPC_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_sel   = IMM_S;
        uses_rs2       = 1'b1;
        no_rd          = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.branch  = 1'b1;
        ctrl.alu_op  = ALU_OP_BRANCH;
        ctrl.imm_sel = IMM_B;
        uses_rs2     = 1'b1;
        no_rd        = 1'b1;
      end
      OPC_OP_IMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_OP_FUNCT;
        ctrl.alu_src   = 1'b1;
      end
      OPC_OP: begin
        uses_rs2 = 1'b1;
        if (funct7 == FUNCT7_MULDIV) begin
`ifdef RV_M_EXT_EN
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALU_OP_MULDIV;
          is_div         = instr[14];
`else
          ctrl.illegal = 1'b1;
`endif
        end else begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALU_OP_FUNCT;
        end
      end
      OPC_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.a_sel     = A_SEL_PC;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_sel   = IMM_J;
      end
      OPC_JALR: begin
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      OPC_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.a_sel     = A_SEL_ZERO;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_sel   = IMM_U;
      end
      OPC_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.a_sel     = A_SEL_PC;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_sel   = IMM_U;
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
  end

  // Stores and branches never write back, so their rd field is zeroed to keep hazard checks quiet.
  assign rd  = no_rd ? '0 : REG_ADDR_W'(instr[11:7]);
  assign rs1 = REG_ADDR_W'(instr[19:15]);
  assign rs2 = REG_ADDR_W'(instr[24:20]);

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered decode/control stage: ID/EX control register with stall, flush and
// load-use bubbles. Define RV_M_EXT_EN to enable M decode and the divide-wait FSM.
module decode_ctrl_stage
  import rv_ctrl_pkg::*;
#(
  parameter int DIV_LATENCY = 4,
  parameter int REG_ADDR_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  input  logic                  flush,
  input  logic                  ex_ready,
  output logic                  out_valid,
  output logic                  out_reg_write,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic                  out_mem_to_reg,
  output logic                  out_branch,
  output logic                  out_jump,
  output logic                  out_alu_src,
  output logic                  out_illegal,
  output logic [1:0]            out_alu_op,
  output logic [1:0]            out_a_sel,
  output logic [2:0]            out_imm_sel,
  output logic [2:0]            out_funct3,
  output logic                  out_funct7_5,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [REG_ADDR_W-1:0] out_rs1,
  output logic [REG_ADDR_W-1:0] out_rs2,
  output logic                  muldiv_busy
);

  ctrl_bundle_t          dec_ctrl;
  ctrl_bundle_t          out_ctrl;
  logic [REG_ADDR_W-1:0] dec_rd;
  logic [REG_ADDR_W-1:0] dec_rs1;
  logic [REG_ADDR_W-1:0] dec_rs2;
  logic                  dec_uses_rs2;
  logic                  dec_is_div;
  logic                  advance;
  logic                  hazard;
  logic                  div_wait;
  logic                  accept;

  ctrl_decode #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_decode (
    .instr    (instr),
    .ctrl     (dec_ctrl),
    .rd       (dec_rd),
    .rs1      (dec_rs1),
    .rs2      (dec_rs2),
    .uses_rs2 (dec_uses_rs2),
    .is_div   (dec_is_div)
  );

  assign advance = !out_valid || ex_ready;
  assign hazard  = out_valid && out_ctrl.mem_read && (out_rd != '0) &&
                   ((dec_rs1 == out_rd) || (dec_uses_rs2 && (dec_rs2 == out_rd)));
  assign in_ready = advance && !flush && !hazard && !div_wait;
  assign accept   = in_valid && in_ready;

  // When advancing without an accepted instruction the register takes a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      out_rd    <= '0;
      out_rs1   <= '0;
      out_rs2   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (advance) begin
      out_valid <= accept;
      out_ctrl  <= dec_ctrl;
      out_rd    <= dec_rd;
      out_rs1   <= dec_rs1;
      out_rs2   <= dec_rs2;
    end
  end

  assign out_reg_write  = out_ctrl.reg_write;
  assign out_mem_read   = out_ctrl.mem_read;
  assign out_mem_write  = out_ctrl.mem_write;
  assign out_mem_to_reg = out_ctrl.mem_to_reg;
  assign out_branch     = out_ctrl.branch;
  assign out_jump       = out_ctrl.jump;
  assign out_alu_src    = out_ctrl.alu_src;
  assign out_illegal    = out_ctrl.illegal;
  assign out_alu_op     = out_ctrl.alu_op;
  assign out_a_sel      = out_ctrl.a_sel;
  assign out_imm_sel    = out_ctrl.imm_sel;
  assign out_funct3     = out_ctrl.funct3;
  assign out_funct7_5   = out_ctrl.funct7_5;

`ifdef RV_M_EXT_EN
  localparam int CNT_W = $clog2(DIV_LATENCY + 1);

  typedef enum logic {
    IDLE     = 1'b0,
    DIV_WAIT = 1'b1
  } div_state_e;

  div_state_e       state;
  div_state_e       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The countdown runs regardless of ex_ready; issue is blocked only by the divider itself.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (flush) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && dec_is_div && (DIV_LATENCY > 1)) begin
            state_next = DIV_WAIT;
            cnt_next   = CNT_W'(DIV_LATENCY - 1);
          end
        end
        DIV_WAIT: begin
          cnt_next = cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign div_wait    = (state == DIV_WAIT);
  assign muldiv_busy = (state != IDLE);
`else
  logic unused_div;
  assign unused_div  = dec_is_div;
  assign div_wait    = 1'b0;
  assign muldiv_busy = 1'b0;
`endif

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Self-checking bench for decode_ctrl_stage: directed scenarios plus random
// stimulus compared against an instruction-level reference model.
module tb_decode_ctrl_stage;

  localparam int DIV_LAT = 4;
  localparam int RAW     = 5;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [31:0]    instr;
  logic           flush;
  logic           ex_ready;
  logic           out_valid;
  logic           out_reg_write;
  logic           out_mem_read;
  logic           out_mem_write;
  logic           out_mem_to_reg;
  logic           out_branch;
  logic           out_jump;
  logic           out_alu_src;
  logic           out_illegal;
  logic [1:0]     out_alu_op;
  logic [1:0]     out_a_sel;
  logic [2:0]     out_imm_sel;
  logic [2:0]     out_funct3;
  logic           out_funct7_5;
  logic [RAW-1:0] out_rd;
  logic [RAW-1:0] out_rs1;
  logic [RAW-1:0] out_rs2;
  logic           muldiv_busy;

  decode_ctrl_stage #(
    .DIV_LATENCY(DIV_LAT),
    .REG_ADDR_W (RAW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .instr          (instr),
    .flush          (flush),
    .ex_ready       (ex_ready),
    .out_valid      (out_valid),
    .out_reg_write  (out_reg_write),
    .out_mem_read   (out_mem_read),
    .out_mem_write  (out_mem_write),
    .out_mem_to_reg (out_mem_to_reg),
    .out_branch     (out_branch),
    .out_jump       (out_jump),
    .out_alu_src    (out_alu_src),
    .out_illegal    (out_illegal),
    .out_alu_op     (out_alu_op),
    .out_a_sel      (out_a_sel),
    .out_imm_sel    (out_imm_sel),
    .out_funct3     (out_funct3),
    .out_funct7_5   (out_funct7_5),
    .out_rd         (out_rd),
    .out_rs1        (out_rs1),
    .out_rs2        (out_rs2),
    .muldiv_busy    (muldiv_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [14:0] val;
    logic [14:0] care;
  } exp_t;

  int          errors;
  int          checks;
  logic        m_valid;
  logic [31:0] m_instr;
  int          m_div_left;

  localparam logic [31:0] LW_X5   = 32'h0000A283;
  localparam logic [31:0] ADD_X6  = 32'h00228333;
  localparam logic [31:0] DIV_X3  = 32'h025241B3;
  localparam logic [31:0] ADDI_X1 = 32'h00100093;
  localparam logic [31:0] ILL_7F  = 32'h0000007F;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Flag vector layout: {rw,mr,mw,m2r,br,jump,src,illegal, alu_op[1:0], a_sel[1:0], imm_sel[2:0]}
  function automatic logic [14:0] fl(input logic [7:0] en, input logic [1:0] op,
                                     input logic [1:0] asel, input logic [2:0] imm);
    return {en, op, asel, imm};
  endfunction

  function automatic exp_t model_flags(input logic [31:0] i);
    exp_t e;
    e.care = '1;
    case (i[6:0])
      7'h03: e.val = fl(8'b1101_0010, 2'd0, 2'd0, 3'd0);
      7'h23: e.val = fl(8'b0010_0010, 2'd0, 2'd0, 3'd1);
      7'h63: e.val = fl(8'b0000_1000, 2'd1, 2'd0, 3'd2);
      7'h13: e.val = fl(8'b1000_0010, 2'd2, 2'd0, 3'd0);
      7'h6F: e.val = fl(8'b1000_0110, 2'd0, 2'd1, 3'd4);
      7'h67: e.val = fl(8'b1000_0110, 2'd0, 2'd0, 3'd0);
      7'h37: e.val = fl(8'b1000_0010, 2'd0, 2'd2, 3'd3);
      7'h17: e.val = fl(8'b1000_0010, 2'd0, 2'd1, 3'd3);
      7'h33: begin
        e.care = 15'b111_1111_1111_1000;
        if (i[31:25] == 7'b0000001) begin
`ifdef RV_M_EXT_EN
          e.val = fl(8'b1000_0000, 2'd3, 2'd0, 3'd0);
`else
          e.val  = fl(8'b0000_0001, 2'd0, 2'd0, 3'd0);
          e.care = 15'b111_1111_1000_0000;
`endif
        end else begin
          e.val = fl(8'b1000_0000, 2'd2, 2'd0, 3'd0);
        end
      end
      default: begin
        e.val  = fl(8'b0000_0001, 2'd0, 2'd0, 3'd0);
        e.care = 15'b111_1111_1000_0000;
      end
    endcase
    return e;
  endfunction

  function automatic logic model_uses_rs2(input logic [31:0] i);
    return (i[6:0] == 7'h33) || (i[6:0] == 7'h23) || (i[6:0] == 7'h63);
  endfunction

  function automatic logic model_is_div(input logic [31:0] i);
`ifdef RV_M_EXT_EN
    return (i[6:0] == 7'h33) && (i[31:25] == 7'b0000001) && i[14];
`else
    return (i[31:0] == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  function automatic logic [4:0] model_rd(input logic [31:0] i);
    if (i[6:0] == 7'h23 || i[6:0] == 7'h63) return 5'd0;
    return i[11:7];
  endfunction

  function automatic logic model_ready(input logic fl_in, input logic exr, input logic [31:0] i);
    logic adv;
    logic haz;
    logic [4:0] ld_rd;
    ld_rd = m_instr[11:7];
    adv = !m_valid || exr;
    haz = m_valid && (m_instr[6:0] == 7'h03) && (ld_rd != 5'd0) &&
          ((i[19:15] == ld_rd) || (model_uses_rs2(i) && (i[24:20] == ld_rd)));
    return adv && !fl_in && !haz && (m_div_left == 0);
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [6:0]  opc;
    logic [6:0]  f7;
    logic [31:0] i;
    case ($urandom_range(0, 10))
      0:  opc = 7'h03;
      1:  opc = 7'h23;
      2:  opc = 7'h63;
      3:  opc = 7'h13;
      4:  opc = 7'h33;
      5:  opc = 7'h6F;
      6:  opc = 7'h67;
      7:  opc = 7'h37;
      8:  opc = 7'h17;
      9:  opc = 7'h33;
      default: opc = 7'h7F;
    endcase
    case ($urandom_range(0, 2))
      0:       f7 = 7'b0000000;
      1:       f7 = 7'b0100000;
      default: f7 = 7'b0000001;
    endcase
    i = {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
         5'($urandom_range(0, 3)), opc};
    return i;
  endfunction

  task automatic checkState();
    exp_t e;
    checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
    checkOutput("muldiv_busy", 32'(muldiv_busy), 32'(m_div_left != 0));
    if (m_valid) begin
      e = model_flags(m_instr);
      checkOutput("flags",
        32'({out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg, out_branch, out_jump,
             out_alu_src, out_illegal, out_alu_op, out_a_sel, out_imm_sel} & e.care),
        32'(e.val & e.care));
      checkOutput("rd", 32'(out_rd), 32'(model_rd(m_instr)));
      checkOutput("rs1", 32'(out_rs1), 32'(m_instr[19:15]));
      checkOutput("rs2", 32'(out_rs2), 32'(m_instr[24:20]));
      checkOutput("funct3", 32'(out_funct3), 32'(m_instr[14:12]));
      checkOutput("funct7_5", 32'(out_funct7_5), 32'(m_instr[30]));
    end
  endtask

  // Drives one cycle of inputs, checks in_ready before the edge and all outputs after it.
  task automatic applyStimulus(input logic iv, input logic [31:0] i, input logic fl_in, input logic exr);
    logic exp_rdy;
    logic acc;
    in_valid = iv;
    instr    = i;
    flush    = fl_in;
    ex_ready = exr;
    #1;
    exp_rdy = model_ready(fl_in, exr, i);
    checkOutput("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    acc = iv && exp_rdy;
    if (fl_in) m_div_left = 0;
    else if (m_div_left > 0) m_div_left = m_div_left - 1;
    else if (acc && model_is_div(i) && DIV_LAT > 1) m_div_left = DIV_LAT - 1;
    if (fl_in) begin
      m_valid = 1'b0;
    end else if (!m_valid || exr) begin
      m_valid = acc;
      m_instr = i;
    end
    @(negedge clk);
    checkState();
  endtask

  logic [31:0] r_instr;

  initial begin
    errors     = 0;
    checks     = 0;
    m_valid    = 1'b0;
    m_instr    = '0;
    m_div_left = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    instr      = '0;
    flush      = 1'b0;
    ex_ready   = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset flags", 32'({out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg,
                out_branch, out_jump, out_alu_src, out_illegal, out_alu_op, out_a_sel, out_imm_sel}), 32'd0);
    checkOutput("reset rd", 32'(out_rd), 32'd0);
    checkOutput("reset busy", 32'(muldiv_busy), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // Load, then a dependent add: one bubble before the add issues.
    applyStimulus(1'b1, LW_X5, 1'b0, 1'b1);
    checkOutput("lw rd", 32'(out_rd), 32'd5);
    checkOutput("lw mem_read", 32'(out_mem_read), 32'd1);
    applyStimulus(1'b1, ADD_X6, 1'b0, 1'b1);
    checkOutput("bubble", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, ADD_X6, 1'b0, 1'b1);
    checkOutput("add alu_op", 32'(out_alu_op), 32'd2);
    checkOutput("add rd", 32'(out_rd), 32'd6);

    // Divide followed by a stream of addi.
    applyStimulus(1'b1, DIV_X3, 1'b0, 1'b1);
    repeat (4) applyStimulus(1'b1, ADDI_X1, 1'b0, 1'b1);

    // Divide held by execute back-pressure.
    applyStimulus(1'b1, DIV_X3, 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b1, ADDI_X1, 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b1, ADDI_X1, 1'b0, 1'b1);

    // Flush during divide wait with an incoming instruction.
    applyStimulus(1'b1, DIV_X3, 1'b0, 1'b1);
    applyStimulus(1'b1, ADDI_X1, 1'b1, 1'b1);
    applyStimulus(1'b1, ADDI_X1, 1'b0, 1'b1);

    // Illegal opcode still issues.
    applyStimulus(1'b1, ILL_7F, 1'b0, 1'b1);
    checkOutput("illegal flag", 32'(out_illegal), 32'd1);
    checkOutput("illegal enables", 32'({out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump}), 32'd0);

    // Reset in the middle of a divide returns everything to idle at once.
    applyStimulus(1'b1, DIV_X3, 1'b0, 1'b1);
    applyStimulus(1'b0, ADDI_X1, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset busy", 32'(muldiv_busy), 32'd0);
    checkOutput("async reset valid", 32'(out_valid), 32'd0);
    m_valid    = 1'b0;
    m_div_left = 0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 600; n++) begin
      r_instr = gen_instr();
      applyStimulus(1'b1 && ($urandom_range(0, 9) < 8), r_instr,
                    ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
